// File: rtl/bus_timer_target_if.sv
// 65C02 target-side bus bundle: address/control/data from the CPU,
// read data, drive enable, RDY and IRQB back to it.
interface bus_timer_target_if;
   logic        BE;
   logic [15:0] AB;
   logic        RWB;
   logic [7:0]  DB_IN;
   logic [7:0]  DB_OUT;
   logic        DB_OE;
   logic        RDY;
   logic        IRQB;

   modport master (
      output BE, AB, RWB, DB_IN,
      input  DB_OUT, DB_OE, RDY, IRQB
   );

   modport slave (
      input  BE, AB, RWB, DB_IN,
      output DB_OUT, DB_OE, RDY, IRQB
   );
endinterface

// File: rtl/bus_timer_target.sv
// 8-byte memory-mapped responder on the 65C02 bus: programmable wait
// states via RDY, a 16-bit down-counting interval timer with prescaler
// and IRQB, plus four scratch bytes.
module bus_timer_target #(
   parameter logic [15:0] BASE_ADDR   = 16'hD000,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned PRESCALE    = 16
) (
   input logic               PHI2,
   input logic               RES,
   bus_timer_target_if.slave bus
);

   localparam int unsigned   PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
   localparam logic [2:0]    WS     = 3'(WAIT_STATES);

   logic [2:0]       wcnt_q, wcnt_d;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic [15:0]      count_q, count_d;
   logic [15:0]      reload_q, reload_d;
   logic             en_q, en_d;
   logic             ar_q, ar_d;
   logic             irq_en_q, irq_en_d;
   logic             if_q, if_d;
   logic [3:0][7:0]  scr_q, scr_d;

   logic       sel;
   logic [2:0] ofs;
   logic       rdy;
   logic       commit_wr;
   logic       wr_lo, wr_hi, wr_ctrl, wr_stat;
   logic       tick;
   logic       set_if;
   logic [7:0] rd_mux;

   // Address decode, wait-state handshake and commit qualification
   always_comb begin
      sel       = bus.BE & (bus.AB[15:3] == BASE_ADDR[15:3]);
      ofs       = bus.AB[2:0];
      rdy       = ~(sel & (wcnt_q != WS));
      commit_wr = sel & rdy & ~bus.RWB;
      wr_lo     = commit_wr & (ofs == 3'd0);
      wr_hi     = commit_wr & (ofs == 3'd1);
      wr_ctrl   = commit_wr & (ofs == 3'd2);
      wr_stat   = commit_wr & (ofs == 3'd3);
      wcnt_d    = (sel & ~rdy) ? wcnt_q + 3'd1 : 3'd0;
   end

   // Read mux; valid for every cycle of a selected read, including waits
   always_comb begin
      rd_mux = '0;
      case (ofs)
         3'd0:    rd_mux = count_q[7:0];
         3'd1:    rd_mux = count_q[15:8];
         3'd2:    rd_mux = {5'b0, irq_en_q, ar_q, en_q};
         3'd3:    rd_mux = {7'b0, if_q};
         default: rd_mux = scr_q[ofs[1:0]];
      endcase
   end

   assign bus.RDY    = rdy;
   assign bus.DB_OE  = sel & bus.RWB;
   assign bus.DB_OUT = (sel & bus.RWB) ? rd_mux : 8'h00;
   assign bus.IRQB   = ~(if_q & irq_en_q);

   // Timer/prescaler next state; register writes are applied after the
   // tick so a coincident CNT_HI load or CTRL write overrides it
   always_comb begin
      pcnt_d   = pcnt_q;
      count_d  = count_q;
      reload_d = reload_q;
      en_d     = en_q;
      ar_d     = ar_q;
      irq_en_d = irq_en_q;
      scr_d    = scr_q;

      tick   = en_q & (pcnt_q == P_LAST);
      set_if = tick & ~wr_hi & (count_q == 16'd0);

      if (!en_q || tick) pcnt_d = '0;
      else               pcnt_d = pcnt_q + PW'(1);

      if (tick && !wr_hi) begin
         if (count_q != 16'd0) count_d = count_q - 16'd1;
         else if (ar_q)        count_d = reload_q;
         else                  en_d    = 1'b0;
      end

      if_d = set_if | (if_q & ~(wr_stat & bus.DB_IN[0]));

      if (wr_lo) reload_d[7:0] = bus.DB_IN;
      if (wr_hi) begin
         reload_d[15:8] = bus.DB_IN;
         count_d        = {bus.DB_IN, reload_q[7:0]};
         pcnt_d         = '0;
      end
      if (wr_ctrl) {irq_en_d, ar_d, en_d} = bus.DB_IN[2:0];
      if (commit_wr && ofs[2]) scr_d[ofs[1:0]] = bus.DB_IN;
   end

   // State registers with synchronous reset; reset also aborts an access
   always_ff @(posedge PHI2) begin
      if (RES) begin
         wcnt_q   <= '0;
         pcnt_q   <= '0;
         count_q  <= '0;
         reload_q <= '0;
         en_q     <= 1'b0;
         ar_q     <= 1'b0;
         irq_en_q <= 1'b0;
         if_q     <= 1'b0;
         scr_q    <= '0;
      end else begin
         wcnt_q   <= wcnt_d;
         pcnt_q   <= pcnt_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         en_q     <= en_d;
         ar_q     <= ar_d;
         irq_en_q <= irq_en_d;
         if_q     <= if_d;
         scr_q    <= scr_d;
      end
   end

endmodule

// File: tb/tb_bus_timer_target.sv
// Scoreboard bench for bus_timer_target: expectations are queued when an
// access or probe is issued and popped when the DUT result is sampled.
module tb_bus_timer_target;

   localparam int unsigned WS = 1;
   localparam int unsigned PS = 16;

   logic PHI2 = 1'b0;
   logic RES  = 1'b1;

   bus_timer_target_if bus();

   bus_timer_target #(
      .BASE_ADDR  (16'hD000),
      .WAIT_STATES(WS),
      .PRESCALE   (PS)
   ) dut (
      .PHI2(PHI2),
      .RES (RES),
      .bus (bus)
   );

   always #5 PHI2 = ~PHI2;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } sb_item_t;

   sb_item_t    sb_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [15:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic sb_check(input logic [15:0] obs);
      sb_item_t it;
      if (sb_q.size() == 0) begin
         check("sb_underflow", 16'(sb_q.size()), 16'd1);
         return;
      end
      it = sb_q.pop_front();
      check(it.tag, obs, it.exp);
   endtask

   task automatic expect_now(input string tag, input logic [15:0] exp, input logic [15:0] obs);
      sb_push(tag, exp);
      sb_check(obs);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge PHI2);
      #1;
   endtask

   task automatic bus_idle();
      bus.BE    = 1'b0;
      bus.AB    = 16'h0000;
      bus.RWB   = 1'b1;
      bus.DB_IN = 8'h00;
   endtask

   // One CPU access, started just after a rising edge; returns just after
   // the edge that ends the completing cycle.
   task automatic bus_access(input logic rw, input logic [15:0] addr, input logic [7:0] wdata,
                             output logic [7:0] rd_first, output logic [7:0] rd_last,
                             output logic oe_all, output int waits);
      logic r;
      logic done;
      bus.BE    = 1'b1;
      bus.AB    = addr;
      bus.RWB   = rw;
      bus.DB_IN = wdata;
      waits     = 0;
      oe_all    = 1'b1;
      done      = 1'b0;
      rd_first  = 8'h00;
      rd_last   = 8'h00;
      for (int i = 0; i < 16 && !done; i++) begin
         @(negedge PHI2);
         if (i == 0) rd_first = bus.DB_OUT;
         rd_last = bus.DB_OUT;
         oe_all  = oe_all & bus.DB_OE;
         r       = bus.RDY;
         @(posedge PHI2);
         #1;
         if (r) done = 1'b1;
         else   waits++;
      end
      bus_idle();
      if (!done) check("rdy_timeout", 16'(done), 16'd1);
   endtask

   task automatic wr(input logic [15:0] addr, input logic [7:0] data);
      logic [7:0] f, l;
      logic       oe;
      int         w;
      sb_push($sformatf("wr_%h_waits", addr), 16'(WS));
      bus_access(1'b0, addr, data, f, l, oe, w);
      sb_check(16'(w));
   endtask

   task automatic rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
      logic [7:0] f, l;
      logic       oe;
      int         w;
      sb_push(tag, {8'h00, exp});
      sb_push({tag, "_waits"}, 16'(WS));
      bus_access(1'b1, addr, 8'h00, f, l, oe, w);
      sb_check({8'h00, l});
      sb_check(16'(w));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] f, l;
      logic       oe;
      int         w;

      // reset and idle on an unrelated address
      bus_idle();
      bus.BE = 1'b1;
      RES = 1'b1;
      cycles(3);
      RES = 1'b0;
      @(negedge PHI2);
      expect_now("rst_rdy",    16'd1, 16'(bus.RDY));
      expect_now("rst_irqb",   16'd1, 16'(bus.IRQB));
      expect_now("rst_db_oe",  16'd0, 16'(bus.DB_OE));
      expect_now("rst_db_out", 16'h00, {8'h00, bus.DB_OUT});
      cycles(1);
      for (int i = 0; i < 8; i++)
         rd($sformatf("rst_rd_ofs%0d", i), 16'hD000 + 16'(i), 8'h00);

      // wait states on scratch write/read
      wr(16'hD004, 8'hA5);
      sb_push("scr0_wait_data", 16'h00A5);
      sb_push("scr0_last_data", 16'h00A5);
      sb_push("scr0_oe_all",    16'd1);
      sb_push("scr0_waits",     16'(WS));
      bus_access(1'b1, 16'hD004, 8'h00, f, l, oe, w);
      sb_check({8'h00, f});
      sb_check({8'h00, l});
      sb_check(16'(oe));
      sb_check(16'(w));

      // auto-reload interval: IF after (3+1)*16 clocks
      wr(16'hD000, 8'h03);
      wr(16'hD001, 8'h00);
      wr(16'hD002, 8'h07);
      cycles(63);
      expect_now("ar_irqb_before", 16'd1, 16'(bus.IRQB));
      cycles(1);
      expect_now("ar_irqb_set", 16'd0, 16'(bus.IRQB));
      rd("ar_cnt_reloaded", 16'hD000, 8'h03);
      expect_now("ar_irqb_held", 16'd0, 16'(bus.IRQB));
      wr(16'hD003, 8'h01);
      expect_now("ar_irqb_cleared", 16'd1, 16'(bus.IRQB));
      wr(16'hD002, 8'h00);
      wr(16'hD003, 8'h01);

      // one-shot: IF after (2+1)*16 clocks, EN auto-clears, count parks at 0
      wr(16'hD000, 8'h02);
      wr(16'hD001, 8'h00);
      wr(16'hD002, 8'h05);
      cycles(47);
      expect_now("os_irqb_before", 16'd1, 16'(bus.IRQB));
      cycles(1);
      expect_now("os_irqb_set", 16'd0, 16'(bus.IRQB));
      rd("os_ctrl", 16'hD002, 8'h04);
      rd("os_stat", 16'hD003, 8'h01);
      rd("os_cnt_lo", 16'hD000, 8'h00);
      cycles(40);
      rd("os_cnt_lo_late", 16'hD000, 8'h00);
      rd("os_cnt_hi_late", 16'hD001, 8'h00);
      expect_now("os_irqb_late", 16'd0, 16'(bus.IRQB));

      // STAT clear committing on the edge where IF sets
      wr(16'hD003, 8'h01);
      rd("coin_stat_pre", 16'hD003, 8'h00);
      wr(16'hD000, 8'h01);
      wr(16'hD001, 8'h00);
      wr(16'hD002, 8'h01);
      cycles(30);
      wr(16'hD003, 8'h01);
      rd("coin_stat_set_wins", 16'hD003, 8'h01);
      rd("coin_ctrl_en_clr", 16'hD002, 8'h00);

      // CNT_HI load committing on a tick edge
      wr(16'hD003, 8'h01);
      wr(16'hD000, 8'h55);
      wr(16'hD001, 8'h00);
      wr(16'hD002, 8'h01);
      cycles(14);
      wr(16'hD001, 8'h01);
      rd("load_cnt_lo", 16'hD000, 8'h55);
      rd("load_cnt_hi", 16'hD001, 8'h01);
      wr(16'hD002, 8'h00);

      // reset in the middle of a stretched write
      bus.BE    = 1'b1;
      bus.AB    = 16'hD005;
      bus.RWB   = 1'b0;
      bus.DB_IN = 8'h77;
      @(negedge PHI2);
      expect_now("res_mid_rdy_low", 16'd0, 16'(bus.RDY));
      RES = 1'b1;
      @(posedge PHI2);
      #1;
      RES = 1'b0;
      bus_idle();
      @(negedge PHI2);
      expect_now("res_rdy_after", 16'd1, 16'(bus.RDY));
      cycles(1);
      rd("res_scr1", 16'hD005, 8'h00);
      rd("res_ctrl", 16'hD002, 8'h00);

      // BE=0 never selects the block
      bus.BE    = 1'b0;
      bus.AB    = 16'hD000;
      bus.RWB   = 1'b0;
      bus.DB_IN = 8'h99;
      @(negedge PHI2);
      expect_now("be0_rdy",    16'd1, 16'(bus.RDY));
      expect_now("be0_db_oe",  16'd0, 16'(bus.DB_OE));
      cycles(1);
      bus.AB  = 16'hD004;
      bus.RWB = 1'b1;
      @(negedge PHI2);
      expect_now("be0_rd_db_oe",  16'd0, 16'(bus.DB_OE));
      expect_now("be0_rd_db_out", 16'h00, {8'h00, bus.DB_OUT});
      bus.RWB = 1'b0;
      cycles(1);
      bus_idle();
      rd("be0_scr0", 16'hD004, 8'h00);
      wr(16'hD001, 8'h00);
      rd("be0_cnt_lo", 16'hD000, 8'h00);

      if (sb_q.size() != 0) check("sb_leftover", 16'(sb_q.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bus_timer_target.md
Name: bus_timer_target

Overview:
- Memory-mapped responder on the 65C02 system bus: the target side of the CPU's address/data/RWB/RDY/IRQB interface.
- Decodes an 8-byte window, inserts programmable wait states via RDY, and serves reads/writes to a 16-bit down-counting interval timer plus 4 scratch bytes.
- The timer raises IRQB (active-low) to the CPU.
- Sits beside RAM/ROM on the bus; the CPU drives AB/RWB/DB, and this block returns read data through a DB driver enable.

Parameters:
- BASE_ADDR, 16'hD000, window base; must be 8-byte aligned.
- WAIT_STATES, 1, RDY-low cycles inserted per access (0..7).
- PRESCALE, 16, clocks per timer decrement (>=1).

Ports:
- PHI2 in 1 system clock; all state updates on rising edge.
- RES in 1 reset; synchronous, active-high.
- BE in 1 bus enable; when 0 the block is never selected.
- AB in 16 address from CPU.
- RWB in 1 1=read, 0=write.
- DB_IN in 8 write data from CPU.
- DB_OUT out 8 read data.
- DB_OE out 1 drive enable for the DB tristate.
- RDY out 1 ready to CPU; 0 stretches the current cycle.
- IRQB out 1 interrupt request, active-low.

Behaviour:
- SEL = BE & (AB[15:3] == BASE_ADDR[15:3]); OFS = AB[2:0]. One bus cycle = one PHI2 period. The CPU holds AB/RWB/DB_IN stable while RDY=0.
- Wait counter wcnt (3 bits):
  - RDY = ~(SEL & (wcnt != WAIT_STATES)), combinational; RDY=1 whenever not selected.
  - While SEL & ~RDY, wcnt increments each clock.
  - On the completing cycle (SEL & RDY), wcnt returns to 0.
  - If SEL drops before completion, wcnt returns to 0 and nothing is committed.
- Write commit happens on the edge ending a completing cycle with RWB=0. Reads have no side effects.
- DB_OE = SEL & RWB; DB_OUT = read mux of OFS when DB_OE is 1, else 8'h00. The read mux is valid during wait cycles too.
- Register map:
  - 0 CNT_LO: read current count[7:0]; write sets reload[7:0].
  - 1 CNT_HI: read count[15:8]; write sets reload[15:8] and loads count = {DB_IN, reload[7:0]}, and resets the prescaler.
  - 2 CTRL: rw, bits[2:0] = {IRQ_EN, AUTO_RELOAD, EN}; bits[7:3] read 0.
  - 3 STAT: bit0 IF. Write 1 clears IF, write 0 has no effect; bits[7:1] read 0.
  - 4..7 SCR0..3: rw scratch bytes.
- Prescaler pcnt counts 0..PRESCALE-1 while EN=1, and is held at 0 while EN=0. tick = EN & (pcnt == PRESCALE-1).
- On tick:
  - count != 0: count decrements.
  - count == 0: IF is set. If AUTO_RELOAD, count = reload; else EN is cleared and count stays 0.
- Decrement wrap: counting 1 -> 0 does not set IF. IF sets on the tick taken while count is at 0, so the period is (reload+1)*PRESCALE clocks.
- IRQB = ~(IF & IRQ_EN), level-sensitive. It stays low until software clears IF or IRQ_EN.
- Simultaneous events:
  - IF set by tick and STAT clear-write in the same cycle: set wins, IF=1.
  - CNT_HI load and tick in the same cycle: the load wins, the tick is discarded, and pcnt resets.
  - CTRL write and tick in the same cycle: the tick uses the old CTRL, and the written value then overrides it (a write of EN=1 beats auto-clear).
- Reset values:
  - count, reload, CTRL, IF, SCR*, wcnt, pcnt = 0.
  - Outputs: RDY=1, IRQB=1, DB_OE=0, DB_OUT=0 (combinational from reset state with SEL=0).
  - RES mid-access aborts it: no commit, wcnt=0.

Test Plan:
- Reset then idle, AB=16'h0000: RDY=1, IRQB=1, DB_OE=0. Read each offset 0..7 at D000..D007: all return 8'h00.
- WAIT_STATES=1, write 8'hA5 to D004: RDY=0 for exactly 1 cycle, then 1. A read of D004 returns A5 after 1 wait cycle, with DB_OE=1 throughout both cycles.
- PRESCALE=16, write D000=03, D001=00, D002=07: IF sets 64 clocks after the CTRL write commits and IRQB goes 0. Count reloads to 3 and IRQB stays 0. Write D003=01: IRQB returns to 1 the next cycle.
- AUTO_RELOAD=0, reload=2, EN=1: after 48 clocks IF=1, CTRL reads 8'h04, and count stays 0 with no further events.
- Clear-write to STAT issued in the exact cycle IF sets: IF reads 1 afterwards. CNT_HI write coincident with a tick: count equals the new loaded value, not loaded-1.
- Assert RES while RDY=0 mid-write to D005: SCR1 stays 00, RDY=1 next cycle. Access with BE=0 at D000: RDY=1, DB_OE=0, no write committed.
